// File: rtl/lector_destinos_pkg.sv
// lector_destinos_pkg: FSM encoding and word-field positions shared by the
// destination reader and the demux/classifier blocks.
package lector_destinos_pkg;
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam int BW_DEF   = 6;
    localparam int DEST_BIT = BW_DEF - 2;
    localparam int VC_BIT   = BW_DEF - 1;
    function automatic int dest_bit(input int bw);
        return bw - 2;
    endfunction
    function automatic int vc_bit(input int bw);
        return bw - 1;
    endfunction
endpackage

// File: rtl/lector_destinos_if.sv
// lector_destinos_if: read side of the D0/D1 destination FIFOs.
// master = the reader (issues pops), slave = the FIFO pair.
interface lector_destinos_if #(parameter int BW = 6) ();
    logic          D0_empty, D1_empty;
    logic          D0_error_output, D1_error_output;
    logic [BW-1:0] D0_data_out, D1_data_out;
    logic          D0_rd, D1_rd;
    modport master (
        input  D0_empty, D1_empty, D0_error_output, D1_error_output, D0_data_out, D1_data_out,
        output D0_rd, D1_rd
    );
    modport slave (
        output D0_empty, D1_empty, D0_error_output, D1_error_output, D0_data_out, D1_data_out,
        input  D0_rd, D1_rd
    );
endinterface

// File: rtl/lector_destinos_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin; the last winner loses the next tie.
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_grant;
    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) last_grant <= 1'b1;
        else if (|grant) last_grant <= grant[1];
    end
endmodule

// File: rtl/lector_destinos.sv
// lector_destinos: round-robin drain of the D0/D1 destination FIFOs onto one
// output port, with per-FIFO saturating counters and a sticky misroute check.
module lector_destinos
    import lector_destinos_pkg::*;
#(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 stall,
    lector_destinos_if.master    fifo,
    output logic [BW-1:0]        data_out,
    output logic                 data_valid,
    output logic                 data_src,
    output logic [CW-1:0]        count0,
    output logic [CW-1:0]        count1,
    output logic                 misroute,
    output logic                 halted
);
    localparam int DB = dest_bit(BW);
    logic [1:0]    state, state_nx, grant;
    logic [BW-1:0] hold;
    logic          err, eligible;
    assign err      = fifo.D0_error_output | fifo.D1_error_output;
    assign eligible = (state == S_RUN) & enable & ~stall & ~err;
    assign halted   = (state == S_HALT);
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .req     ({eligible & ~fifo.D1_empty, eligible & ~fifo.D0_empty}),
        .grant   (grant)
    );
    assign fifo.D0_rd = grant[0];
    assign fifo.D1_rd = grant[1];
    // FIFO read data is already registered in the FIFO, so the word is steered
    // straight through in the cycle after the pop and held afterwards.
    assign data_out = data_valid ? (data_src ? fifo.D1_data_out : fifo.D0_data_out) : hold;
    always_comb begin
        state_nx = (state == S_WAIT) ? (enable ? S_RUN : S_WAIT) :
                   (state == S_RUN)  ? (err ? S_HALT : enable ? S_RUN : S_WAIT) :
                                       (enable ? S_HALT : S_WAIT);
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= S_WAIT;
            data_valid <= 1'b0;
            data_src   <= 1'b0;
            hold       <= '0;
            count0     <= '0;
            count1     <= '0;
            misroute   <= 1'b0;
        end else begin
            state      <= state_nx;
            data_valid <= |grant;
            data_src   <= grant[1];
            hold       <= data_out;
            if (data_valid & ~data_src & (count0 != '1)) count0 <= count0 + 1'b1;
            if (data_valid & data_src & (count1 != '1)) count1 <= count1 + 1'b1;
            if (data_valid & (data_out[DB] != data_src)) misroute <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lector_destinos.sv
// tb_lector_destinos: directed checks of lector_destinos against a FIFO-pair
// model; inputs change 1 after the rising edge, outputs sampled on the falling edge.
module tb_lector_destinos;
    logic       clk = 1'b0;
    logic       reset_L, enable, stall;
    logic [5:0] data_out;
    logic       data_valid, data_src, misroute, halted;
    logic [7:0] count0, count1;
    int         n_cmp = 0, n_err = 0;
    logic [5:0] m0 [0:1023];
    logic [5:0] m1 [0:1023];
    int         w0 = 0, w1 = 0, r0 = 0, r1 = 0;
    logic [5:0] d0q, d1q;

    lector_destinos_if #(.BW(6)) ifc ();

    lector_destinos #(.BW(6), .CW(8)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .stall      (stall),
        .fifo       (ifc),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_src   (data_src),
        .count0     (count0),
        .count1     (count1),
        .misroute   (misroute),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign ifc.D0_empty    = (w0 == r0);
    assign ifc.D1_empty    = (w1 == r1);
    assign ifc.D0_data_out = d0q;
    assign ifc.D1_data_out = d1q;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0q <= '0;
            d1q <= '0;
        end else begin
            if (ifc.D0_rd) begin d0q <= m0[r0]; r0 <= r0 + 1; end
            if (ifc.D1_rd) begin d1q <= m1[r1]; r1 <= r1 + 1; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [5:0] w);
        m0[w0] = w;
        w0++;
    endtask

    task automatic push1(input logic [5:0] w);
        m1[w1] = w;
        w1++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int n_rd0, n_rd1, viol, alt_err, pops, valids;
        logic seen, exp_src;
        reset_L = 1'b0;
        enable  = 1'b0;
        stall   = 1'b0;
        ifc.D0_error_output = 1'b0;
        ifc.D1_error_output = 1'b0;
        push0(6'b100001); push0(6'b101100);
        push1(6'b111111); push1(6'b110101);
        #12;
        chk("rst_rd0", ifc.D0_rd, 0);
        chk("rst_rd1", ifc.D1_rd, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_counts", {count1, count0}, 0);
        chk("rst_flags", {misroute, halted, data_src}, 0);

        // alternating pops, D0 first
        nxt(); reset_L = 1'b1;
        nxt(); enable = 1'b1;
        nxt(); smp();
        chk("t1_a_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b01);
        nxt(); smp();
        chk("t1_b_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b10);
        chk("t1_b_out", {data_valid, data_src, data_out}, {2'b10, 6'b100001});
        nxt(); smp();
        chk("t1_c_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b01);
        chk("t1_c_out", {data_valid, data_src, data_out}, {2'b11, 6'b111111});
        nxt(); smp();
        chk("t1_d_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b10);
        chk("t1_d_out", {data_valid, data_src, data_out}, {2'b10, 6'b101100});
        nxt(); smp();
        chk("t1_e_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b00);
        chk("t1_e_out", {data_valid, data_src, data_out}, {2'b11, 6'b110101});
        nxt(); smp();
        chk("t1_f_hold", {data_valid, data_out}, {1'b0, 6'b110101});
        chk("t1_counts", {count1, count0}, {8'd2, 8'd2});
        chk("t1_misroute", misroute, 0);
        nxt();

        // D1 empty, 16 words in D0
        n_rd0 = 0; n_rd1 = 0; seen = 1'b0;
        for (int i = 0; i < 16; i++) push0({2'b00, 4'(i)});
        for (int i = 0; i < 20; i++) begin
            smp();
            if (ifc.D0_rd) n_rd0++;
            if (ifc.D1_rd) n_rd1++;
            if (ifc.D0_empty && !seen) begin
                seen = 1'b1;
                chk("t2_rd_after_empty", ifc.D0_rd, 0);
            end
            nxt();
        end
        chk("t2_rd0_cycles", n_rd0, 16);
        chk("t2_rd1_cycles", n_rd1, 0);
        chk("t2_count0", count0, 18);

        // stall every other cycle, both FIFOs loaded
        viol = 0; alt_err = 0; pops = 0; valids = 0; exp_src = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push0(6'h01 + 6'(i));
            push1(6'h11 + 6'(i));
        end
        for (int i = 0; i < 30; i++) begin
            stall = (i % 2 == 0);
            smp();
            if (stall && (ifc.D0_rd || ifc.D1_rd)) viol++;
            if (ifc.D0_rd && ifc.D1_rd) viol++;
            if (ifc.D0_rd || ifc.D1_rd) begin
                if (ifc.D1_rd != exp_src) alt_err++;
                exp_src = ~ifc.D1_rd;
                pops++;
            end
            if (data_valid) valids++;
            nxt();
        end
        stall = 1'b0;
        chk("t3_stall_viol", viol, 0);
        chk("t3_alternation", alt_err, 0);
        chk("t3_pops", pops, 12);
        chk("t3_valids", valids, 12);
        chk("t3_counts", {count1, count0}, {8'd8, 8'd24});

        // misrouted word in D1
        push1(6'b100001);
        smp();
        chk("t4_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b10);
        nxt(); smp();
        chk("t4_valid", {data_valid, data_src, data_out}, {2'b11, 6'b100001});
        chk("t4_mis_early", misroute, 0);
        nxt(); smp();
        chk("t4_mis_set", misroute, 1);
        nxt();
        push0(6'h01); push0(6'h02); push1(6'h11); push1(6'h12);
        for (int i = 0; i < 6; i++) nxt();
        smp();
        chk("t4_mis_sticky", misroute, 1);
        chk("t4_counts", {count1, count0}, {8'd11, 8'd26});
        nxt();

        // error while both FIFOs are non-empty
        push0(6'h03); push0(6'h04); push1(6'h13); push1(6'h14);
        ifc.D0_error_output = 1'b1;
        smp();
        chk("t5_err_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b00);
        chk("t5_err_halted", halted, 0);
        nxt();
        ifc.D0_error_output = 1'b0;
        smp();
        chk("t5_halted", halted, 1);
        chk("t5_halt_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b00);
        nxt(); nxt(); nxt(); smp();
        chk("t5_halt_hold", {halted, ifc.D1_rd, ifc.D0_rd}, 3'b100);
        nxt();
        enable = 1'b0;
        smp();
        chk("t5_halt_last", halted, 1);
        nxt(); smp();
        chk("t5_wait", halted, 0);
        nxt();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) nxt();
        smp();
        chk("t5_counts", {count1, count0}, {8'd13, 8'd28});
        nxt();

        // saturation of count0
        for (int i = 0; i < 240; i++) push0(6'h05);
        for (int i = 0; i < 250; i++) nxt();
        smp();
        chk("t6_count0_sat", count0, 255);
        chk("t6_count1", count1, 13);
        nxt();

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            push0(6'h21);
            push1(6'h31);
        end
        nxt(); nxt(); smp();
        chk("t7_inflight", data_valid, 1);
        #2 reset_L = 1'b0;
        #1;
        chk("t7_rd", {ifc.D1_rd, ifc.D0_rd}, 2'b00);
        chk("t7_data_out", data_out, 0);
        chk("t7_valid_src", {data_valid, data_src}, 2'b00);
        chk("t7_counts", {count1, count0}, 0);
        chk("t7_flags", {misroute, halted}, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lector_destinos.md
# lector_destinos

Output-side drain controller for the QoS switch. Pops words from the D0 and D1 destination FIFOs with a round-robin arbiter and merges them onto one registered output port. Checks that each word's destination bit matches the FIFO it came from, and keeps per-destination word counters. It is the reader counterpart of the Main-FIFO writer. It replaces hand-driven D0_rd/D1_rd in system-level benches and in the integrated design.

## Interface
Parameters:
- BW, 6, word width; bit BW-1 = VC select, bit BW-2 = destination (0→D0, 1→D1)
- CW, 8, width of each word counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- enable  in  1  drain enable; 0 holds all reads off
- stall  in  1  downstream back-pressure; 1 blocks new pops this cycle
- D0_empty, D1_empty  in  1 each  FIFO empty flags
- D0_error_output, D1_error_output  in  1 each  FIFO error flags
- D0_data_out, D1_data_out  in  BW each  FIFO read data, valid the cycle after the rd
- D0_rd, D1_rd  out  1 each  pop strobes (combinational from state and flags)
- data_out  out  BW  merged word (registered)
- data_valid  out  1  data_out valid this cycle (registered)
- data_src  out  1  source of data_out (0=D0, 1=D1)
- count0, count1  out  CW each  words popped per FIFO, saturating
- misroute  out  1  sticky; a word's destination bit disagreed with its source
- halted  out  1  FSM is in HALT

## Operation
- FSM states: WAIT, RUN, HALT. Reset state is WAIT.
- WAIT → RUN when enable=1.
- RUN → WAIT when enable=0.
- RUN → HALT when D0_error_output or D1_error_output is 1.
- HALT → WAIT only when enable=0. Error inputs are ignored in HALT.
- A read is eligible only in RUN, with stall=0, enable=1 and no error input asserted this cycle.
- D0_rd = eligible & ~D0_empty & (D1_empty | last_grant==1).
- D1_rd = eligible & ~D1_empty & (D0_empty | last_grant==0).
- D0_rd and D1_rd are never 1 in the same cycle.
- last_grant register: updates to the granted FIFO on each pop and resets to 1, so D0 wins the first tie.
- Cycle after a pop:
  - data_valid=1.
  - data_src = granted FIFO.
  - data_out = that FIFO's data_out.
  - The matching counter increments, holding at 2^CW−1 (no wrap).
  - If data_out[BW-2] != data_src, set misroute (sticky until reset).
- With no pop, data_valid=0 and data_out holds its last value.
- The counters do not clear on enable or HALT, only on reset.

## Timing
- All outputs are 0 at reset: D0_rd, D1_rd, data_out, data_valid, data_src, count0, count1, misroute, halted. last_grant resets to 1.
- D0_rd/D1_rd are combinational; they are sampled by the FIFO at the same edge that updates last_grant.
- Latency: rd asserted in cycle N gives data_valid and data_out in cycle N+1. Count and misroute are updated at the end of cycle N+1, visible in N+2.
- Throughput: one word per cycle. With both FIFOs non-empty the grants strictly alternate D0, D1, D0, …
- Empty boundary: a FIFO that goes empty stops being granted in the same cycle, and the other FIFO takes every slot.
- stall=1: no rd that cycle. A word already in flight still appears with data_valid the next cycle.
- Error with simultaneous not-empty: the error wins, no rd is issued, and the FSM enters HALT at the next edge.
- Async reset mid-transfer: the in-flight word is discarded and outputs clear immediately without a clock.

## Structure
- Shared package holds:
  - the FSM state encoding (WAIT=2'd0, RUN=2'd1, HALT=2'd2);
  - the DEST_BIT = BW-2 and VC_BIT = BW-1 constants, shared with the demux/classifier blocks.
- One natural sub-module, rr_arbiter2: 2-requester round-robin with a last_grant register, reusable in the VC stage.
- The counters and checker stay inline.

## Test plan
- Reset, enable=1, D0 holds 10_0001 and 10_1100, D1 holds 11_1111 and 11_0101.
  - Pops go D0, D1, D0, D1.
  - data_out is 10_0001, 11_1111, 10_1100, 11_0101.
  - End state: count0=2, count1=2, misroute=0.
- D1 empty, D0 holds 16 words.
  - 16 consecutive D0_rd cycles, count0=16.
  - D0_rd=0 on the first cycle after D0_empty rises.
- Stall toggled every other cycle with both FIFOs full.
  - Pops occur only in stall=0 cycles and still alternate.
  - No word is lost; the counts sum to the words popped.
- Word 10_0001 placed in D1.
  - misroute=1 two cycles after the pop.
  - It stays 1 while further correct words flow.
- D0_error_output pulsed while both FIFOs are non-empty.
  - No rd in the error cycle, halted=1 next cycle.
  - halted stays 1 after the error clears, until enable=0, then WAIT.
- Preload count0 = 255 using CW=8 and pop more words.
  - count0 stays 255.
- Assert reset_L=0 between clock edges mid-stream.
  - All outputs are 0 at once.
